cmd_stream_sequencer: RTL
=========================

// Module: cmd_stream_sequencer
// PURPOSE
//   Consumes a valid/ready stream of package-typed commands and turns it into a
//   registered valid/ready stream of data beats, with a last flag.
//   Sits directly upstream of the enum-import consumer cases in the ch26 corpus.
//   Its command and state enums come from the shared package via a wildcard
//   import, so enum literals resolve unqualified.
//   No local declaration may reuse a literal name; such a name conflicts with
//   the wildcard import.
// PARAMETERS
//   DATA_W   8   width of in_data/out_data and base register
//   CNT_W    4   width of step counter; CNT_MAX = 2**CNT_W-1 auto-terminates a burst
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   in_valid   in   1       command valid
//   in_ready   out  1       command accepted when in_valid && in_ready
//   in_cmd     in   cmd_t   CMD_NOP/CMD_LOAD/CMD_STEP/CMD_FLUSH (2 bits)
//   in_data    in   DATA_W  base value, used only by CMD_LOAD
//   out_valid  out  1       output beat valid
//   out_ready  in   1       downstream accepts beat
//   out_data   out  DATA_W  base + count, modulo 2**DATA_W
//   out_last   out  1       final beat of a burst
//   err_o      out  1       one-cycle pulse: STEP/FLUSH accepted while ST_IDLE
//   state_o    out  state_t current FSM state (ST_IDLE/ST_ACTIVE/ST_HOLD)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//     - state=ST_IDLE; base=0; count=0.
//     - out_valid=0, out_data=0, out_last=0, err_o=0.
//     - Reset mid-burst drops any pending beat with no handshake.
//   Output register and stall
//     - One-entry output register: in_ready = !out_valid || out_ready.
//     - The register holds out_data/out_last stable while out_valid && !out_ready.
//     - state=ST_HOLD for exactly the stalled cycles.
//     - On release, state returns to ST_ACTIVE, or ST_IDLE if the held beat was last.
//   Accepted commands (latency 1 cycle to out_valid)
//     - CMD_NOP: no effect in any state.
//     - CMD_LOAD:
//       - base=in_data, count=0, state->ST_ACTIVE; no beat emitted.
//       - In ST_ACTIVE it reloads and abandons the burst without a last beat.
//     - CMD_STEP in ST_ACTIVE:
//       - Emit out_data=base+count, then count++.
//       - If count==CNT_MAX: out_last=1, count=0, state->ST_IDLE (auto-flush).
//     - CMD_FLUSH in ST_ACTIVE:
//       - Emit base+count with out_last=1, count=0, state->ST_IDLE.
//     - STEP/FLUSH in ST_IDLE: dropped, no beat, err_o=1 next cycle.
//   Simultaneous events
//     - Output pop and new accept in the same cycle: new beat replaces the old;
//       out_valid stays 1.
//   Arithmetic
//     - The adder is DATA_W wide and truncates carry (0xFF+0x02 -> 0x01).
//     - count is zero-extended to DATA_W.
// STRUCTURE
//   Package seq_pkg
//     - typedef enum logic [1:0] {CMD_NOP,CMD_LOAD,CMD_STEP,CMD_FLUSH} cmd_t
//     - typedef enum logic [1:0] {ST_IDLE,ST_ACTIVE,ST_HOLD} state_t
//   Module body
//     - Imports with `import seq_pkg::*;` inside the module.
//     - No explicit type-only import; that form would not make the literals visible.
//   Sub-module: seq_out_reg (one-entry valid/ready output register with data+last).
//     - FSM, counter and adder stay in the top module.
// TESTING
//   1. Reset
//      - Hold rst_n=0 two cycles with in_valid=1.
//      - Expect out_valid=0, state_o=ST_IDLE, in_ready=1.
//   2. LOAD then STEP bursts
//      - LOAD 0x10, STEP x3, FLUSH with out_ready=1.
//      - Expect beats 0x10, 0x11, 0x12 (last=0), then 0x13 (last=1).
//      - Expect state_o back to ST_IDLE.
//   3. Wrap and auto-flush
//      - LOAD 0xFE, then 16 STEPs (CNT_W=4).
//      - Expect beats 0xFE, 0xFF, 0x00...0x0D.
//      - Expect the 16th beat (0x0D) with last=1 and state ST_IDLE.
//   4. Backpressure
//      - LOAD 0x20, STEP, STEP with out_ready=0 for 3 cycles.
//      - Expect 0x20 held stable, in_ready=0, state_o=ST_HOLD.
//      - Release: expect 0x20 then 0x21, no loss or duplication.
//   5. Illegal in IDLE
//      - From reset, STEP.
//      - Expect err_o pulse one cycle, no out_valid.
//      - Then LOAD 0x05, FLUSH: expect single beat 0x05, last=1.
//   6. Reset mid-burst
//      - LOAD 0x40, STEP with out_ready=0, then rst_n=0 one cycle.
//      - Expect out_valid=0 and ST_IDLE next cycle.
//      - Expect the next burst to start at count 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared command/state enums for the command stream sequencer and its consumers.
// Pure type definitions: no latency, no flow control.
package seq_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_FLUSH = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_out_reg.sv
// One-entry valid/ready output register carrying data plus a last flag; 1-cycle latency.
// Accepts when empty or being drained (push_ready = !out_valid || out_ready); holds contents stable while stalled.
module seq_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  assign push_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (push_valid && push_ready) begin
      // a push coinciding with a pop replaces the old beat; valid stays high
      out_valid <= 1'b1;
      out_data  <= push_data;
      out_last  <= push_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_stream_sequencer.sv
// Turns LOAD/STEP/FLUSH commands into a registered stream of base+count beats; 1-cycle latency.
// Commands stall (in_ready=0) while the output beat is held by downstream backpressure.
module cmd_stream_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  cmd_t              in_cmd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_o,
  output state_t            state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] base;
  logic [CNT_W-1:0]  count;
  logic              err_q;
  logic              accept;
  logic              active;
  logic              push_valid;
  logic              push_last;
  logic [DATA_W-1:0] sum;

  assign accept = in_valid && in_ready;
  assign active = (state == ST_ACTIVE);
  assign sum    = base + DATA_W'(count);

  always_comb begin
    push_valid = 1'b0;
    push_last  = 1'b0;
    if (accept && active) begin
      case (in_cmd)
        CMD_STEP: begin
          push_valid = 1'b1;
          push_last  = (count == CNT_MAX);
        end
        CMD_FLUSH: begin
          push_valid = 1'b1;
          push_last  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      base  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !active && (in_cmd == CMD_STEP || in_cmd == CMD_FLUSH);
      if (accept) begin
        case (in_cmd)
          CMD_LOAD: begin
            base  <= in_data;
            count <= '0;
            state <= ST_ACTIVE;
          end
          CMD_STEP: begin
            if (active) begin
              if (count == CNT_MAX) begin
                count <= '0;
                state <= ST_IDLE;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          CMD_FLUSH: begin
            if (active) begin
              count <= '0;
              state <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // HOLD is a view of the stall, so it tracks the stalled cycles exactly
  assign state_o = (out_valid && !out_ready) ? ST_HOLD : state;
  assign err_o   = err_q;

  seq_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (in_ready),
    .push_data  (sum),
    .push_last  (push_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

endmodule
